// File: rtl/hw_supervisor_pkg.sv
// Purpose: shared state/status-code encodings and status_word layout for hw_supervisor.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package hw_supervisor_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd1,
        ST_POWERON   = 4'd2,
        ST_START_DMA = 4'd3,
        ST_START_SPI = 4'd4,
        ST_RUNNING   = 4'd5,
        ST_HALTED    = 4'd6,
        ST_STOPPING  = 4'd7
    } state_t;

    localparam logic [7:0] CODE_OK                = 8'h01;
    localparam logic [7:0] CODE_PS_SHUTDOWN       = 8'h02;
    localparam logic [7:0] CODE_BUF_FILL_TIMEOUT  = 8'h03;
    localparam logic [7:0] CODE_SPI_START_TIMEOUT = 8'h04;
    localparam logic [7:0] CODE_OVER_THRESH       = 8'h05;
    localparam logic [7:0] CODE_SHUTDOWN_SENSE    = 8'h06;
    localparam logic [7:0] CODE_EXT_SHUTDOWN      = 8'h07;
    localparam logic [7:0] CODE_DAC_EMPTY_READ    = 8'h08;
    localparam logic [7:0] CODE_ADC_FULL_WRITE    = 8'h09;
    localparam logic [7:0] CODE_PREMAT_TRIG       = 8'h0A;
    localparam logic [7:0] CODE_PREMAT_DAC_DIV    = 8'h0B;
    localparam logic [7:0] CODE_PREMAT_ADC_DIV    = 8'h0C;
    localparam logic [7:0] CODE_SPI_STOP_TIMEOUT  = 8'h0D;

    // Fault codes occupy a contiguous range whose numeric order is also the
    // reporting priority (lowest code wins).
    localparam int FAULT_CODE_LO = 5;
    localparam int FAULT_CODE_HI = 12;

    localparam int SW_STATE_LSB = 0;
    localparam int SW_CODE_LSB  = 4;
    localparam int SW_BOARD_LSB = 12;

endpackage

// File: rtl/hw_supervisor_if.sv
// Purpose: bundle of PS/board-facing signals of hw_supervisor; master = supervisor, slave = environment.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are levels except the ps_interrupt pulse.
interface hw_supervisor_if #(
    parameter int N_BOARDS = 8,
    parameter int BOARD_W  = 8,
    parameter int TIMER_W  = 32
);
    logic                sys_en;
    logic [TIMER_W-1:0]  poweron_wait;
    logic [TIMER_W-1:0]  buf_load_wait;
    logic [TIMER_W-1:0]  spi_start_wait;
    logic [TIMER_W-1:0]  spi_stop_wait;
    logic [15:0]         fault_mask;
    logic                dac_buf_full;
    logic                spi_running;
    logic                ext_shutdown;
    logic                shutdown_sense;
    logic [BOARD_W-1:0]  sense_num;
    logic [N_BOARDS-1:0] over_thresh;
    logic [N_BOARDS-1:0] dac_empty_read;
    logic [N_BOARDS-1:0] adc_full_write;
    logic [N_BOARDS-1:0] premat_trig;
    logic [N_BOARDS-1:0] premat_dac_div;
    logic [N_BOARDS-1:0] premat_adc_div;
    logic                sys_rst;
    logic                dma_en;
    logic                spi_en;
    logic                trig_en;
    logic                shutdown_force;
    logic                n_shutdown_rst;
    logic [31:0]         status_word;
    logic [15:0]         fault_bitmap;
    logic                ps_interrupt;

    modport master (
        input  sys_en, poweron_wait, buf_load_wait, spi_start_wait, spi_stop_wait,
               fault_mask, dac_buf_full, spi_running, ext_shutdown, shutdown_sense,
               sense_num, over_thresh, dac_empty_read, adc_full_write, premat_trig,
               premat_dac_div, premat_adc_div,
        output sys_rst, dma_en, spi_en, trig_en, shutdown_force, n_shutdown_rst,
               status_word, fault_bitmap, ps_interrupt
    );

    modport slave (
        output sys_en, poweron_wait, buf_load_wait, spi_start_wait, spi_stop_wait,
               fault_mask, dac_buf_full, spi_running, ext_shutdown, shutdown_sense,
               sense_num, over_thresh, dac_empty_read, adc_full_write, premat_trig,
               premat_dac_div, premat_adc_div,
        input  sys_rst, dma_en, spi_en, trig_en, shutdown_force, n_shutdown_rst,
               status_word, fault_bitmap, ps_interrupt
    );
endinterface

// File: rtl/hw_supervisor_lsb_encoder.sv
// Purpose: reports whether any bit of vec is set and the index of the lowest set bit.
// Latency: combinational.
// Backpressure: none.
// Ports: vec (WIDTH) in; vld out; idx (IDX_W) out, 0 when vld is low.
module lsb_encoder #(
    parameter int WIDTH = 8,
    parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] vec,
    output logic             vld,
    output logic [IDX_W-1:0] idx
);
    always_comb begin
        vld = |vec;
        idx = '0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) idx = IDX_W'(i);
        end
    end
endmodule

// File: rtl/hw_supervisor.sv
// Purpose: sequences board power-on/DMA/SPI start, monitors faults, halts and reports first cause + board.
// Latency: 1 cycle from input to registered outputs; ps_interrupt is a registered single-cycle pulse.
// Backpressure: none; inputs are levels sampled every cycle. Ports: clk, rst (sync, active-high), bus (hw_supervisor_if.master).
// Build option: HW_SUPERVISOR_FAULT_LOG_EN enables the fault_bitmap snapshot register; otherwise fault_bitmap is 0.
module hw_supervisor
    import hw_supervisor_pkg::*;
#(
    parameter int N_BOARDS = 8,
    parameter int BOARD_W  = 8,
    parameter int TIMER_W  = 32
) (
    input  logic           clk,
    input  logic           rst,
    hw_supervisor_if.master bus
);
    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d, wait_sel;
    logic [7:0]         code_q, code_d;
    logic [BOARD_W-1:0] board_q, board_d;
    logic sys_rst_q, sys_rst_d, force_q, force_d, nsr_q, nsr_d;
    logic dma_q, dma_d, spi_q, spi_d, trig_q, trig_d;
    logic irq_q, irq_d, pend_q, pend_d;
    logic timeout, halt, enter_irq;
    logic [7:0]         halt_code;
    logic [BOARD_W-1:0] halt_board;

    // Per-board fault buses: one lowest-index encoder each.
    logic               ot_vld, der_vld, afw_vld, pt_vld, pdd_vld, pad_vld;
    logic [BOARD_W-1:0] ot_idx, der_idx, afw_idx, pt_idx, pdd_idx, pad_idx;

    lsb_encoder #(.WIDTH(N_BOARDS), .IDX_W(BOARD_W)) u_enc_ot  (.vec(bus.over_thresh),    .vld(ot_vld),  .idx(ot_idx));
    lsb_encoder #(.WIDTH(N_BOARDS), .IDX_W(BOARD_W)) u_enc_der (.vec(bus.dac_empty_read), .vld(der_vld), .idx(der_idx));
    lsb_encoder #(.WIDTH(N_BOARDS), .IDX_W(BOARD_W)) u_enc_afw (.vec(bus.adc_full_write), .vld(afw_vld), .idx(afw_idx));
    lsb_encoder #(.WIDTH(N_BOARDS), .IDX_W(BOARD_W)) u_enc_pt  (.vec(bus.premat_trig),    .vld(pt_vld),  .idx(pt_idx));
    lsb_encoder #(.WIDTH(N_BOARDS), .IDX_W(BOARD_W)) u_enc_pdd (.vec(bus.premat_dac_div), .vld(pdd_vld), .idx(pdd_idx));
    lsb_encoder #(.WIDTH(N_BOARDS), .IDX_W(BOARD_W)) u_enc_pad (.vec(bus.premat_adc_div), .vld(pad_vld), .idx(pad_idx));

    // fault_act bit k = unmasked source with status code k active this cycle.
    logic [15:0]        fault_act;
    logic               fault_any;
    logic [7:0]         fault_code;
    logic [BOARD_W-1:0] fault_board;

    always_comb begin
        fault_act     = '0;
        fault_act[5]  = ot_vld;
        fault_act[6]  = bus.shutdown_sense;
        fault_act[7]  = bus.ext_shutdown;
        fault_act[8]  = der_vld;
        fault_act[9]  = afw_vld;
        fault_act[10] = pt_vld;
        fault_act[11] = pdd_vld;
        fault_act[12] = pad_vld;
        fault_act     = fault_act & ~bus.fault_mask;
        fault_any     = |fault_act;
        fault_code    = CODE_OK;
        for (int k = FAULT_CODE_HI; k >= FAULT_CODE_LO; k--) begin
            if (fault_act[k]) fault_code = 8'(k);
        end
        case (fault_code)
            CODE_OVER_THRESH:    fault_board = ot_idx;
            CODE_SHUTDOWN_SENSE: fault_board = bus.sense_num;
            CODE_DAC_EMPTY_READ: fault_board = der_idx;
            CODE_ADC_FULL_WRITE: fault_board = afw_idx;
            CODE_PREMAT_TRIG:    fault_board = pt_idx;
            CODE_PREMAT_DAC_DIV: fault_board = pdd_idx;
            CODE_PREMAT_ADC_DIV: fault_board = pad_idx;
            default:             fault_board = '0;
        endcase
    end

    // Timeouts are read live every cycle so software may retune them at any time.
    always_comb begin
        case (state_q)
            ST_POWERON:   wait_sel = bus.poweron_wait;
            ST_START_DMA: wait_sel = bus.buf_load_wait;
            ST_START_SPI: wait_sel = bus.spi_start_wait;
            ST_STOPPING:  wait_sel = bus.spi_stop_wait;
            default:      wait_sel = '0;
        endcase
        // >= rather than == so a wait lowered below the running count still fires.
        timeout = (timer_q >= wait_sel);
    end

    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        board_d    = board_q;
        sys_rst_d  = sys_rst_q;
        force_d    = force_q;
        nsr_d      = nsr_q;
        dma_d      = dma_q;
        spi_d      = spi_q;
        trig_d     = trig_q;
        halt       = 1'b0;
        halt_code  = CODE_OK;
        halt_board = '0;

        case (state_q)
            ST_IDLE: if (bus.sys_en) begin
                state_d   = ST_POWERON;
                sys_rst_d = 1'b0;
                force_d   = 1'b0;
                nsr_d     = 1'b0;
            end
            ST_POWERON: begin
                if (!bus.sys_en) begin
                    halt = 1'b1; halt_code = CODE_PS_SHUTDOWN;
                end else if (timeout) begin
                    state_d = ST_START_DMA;
                    nsr_d   = 1'b1;
                    dma_d   = 1'b1;
                end
            end
            ST_START_DMA: begin
                if (!bus.sys_en) begin
                    halt = 1'b1; halt_code = CODE_PS_SHUTDOWN;
                end else if (bus.dac_buf_full) begin
                    state_d = ST_START_SPI;
                    spi_d   = 1'b1;
                end else if (timeout) begin
                    halt = 1'b1; halt_code = CODE_BUF_FILL_TIMEOUT;
                end
            end
            ST_START_SPI: begin
                if (!bus.sys_en) begin
                    halt = 1'b1; halt_code = CODE_PS_SHUTDOWN;
                end else if (bus.spi_running) begin
                    state_d = ST_RUNNING;
                    trig_d  = 1'b1;
                end else if (timeout) begin
                    halt = 1'b1; halt_code = CODE_SPI_START_TIMEOUT;
                end
            end
            ST_RUNNING: begin
                if (fault_any) begin
                    halt = 1'b1; halt_code = fault_code; halt_board = fault_board;
                end else if (!bus.sys_en) begin
                    state_d = ST_STOPPING;
                    trig_d  = 1'b0;
                    spi_d   = 1'b0;
                end
            end
            ST_STOPPING: begin
                if (fault_any) begin
                    halt = 1'b1; halt_code = fault_code; halt_board = fault_board;
                end else if (!bus.spi_running) begin
                    halt = 1'b1; halt_code = CODE_PS_SHUTDOWN;
                end else if (timeout) begin
                    halt = 1'b1; halt_code = CODE_SPI_STOP_TIMEOUT;
                end
            end
            ST_HALTED: if (!bus.sys_en) begin
                state_d = ST_IDLE;
                code_d  = CODE_OK;
                board_d = '0;
            end
            default: state_d = ST_IDLE;
        endcase

        if (halt) begin
            state_d   = ST_HALTED;
            sys_rst_d = 1'b1;
            force_d   = 1'b1;
            dma_d     = 1'b0;
            spi_d     = 1'b0;
            trig_d    = 1'b0;
            code_d    = halt_code;
            board_d   = halt_board;
        end

        timer_d = (state_d != state_q) ? '0 :
                  (timer_q < wait_sel) ? timer_q + 1'b1 : timer_q;

        // A halt right on the first RUNNING cycle would make two back-to-back
        // pulses; the second is deferred one cycle so the PS sees both edges.
        enter_irq = (state_d != state_q) && (state_d == ST_RUNNING || state_d == ST_HALTED);
        irq_d     = (enter_irq || pend_q) && !irq_q;
        pend_d    = (enter_irq || pend_q) && irq_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            code_q    <= CODE_OK;
            board_q   <= '0;
            sys_rst_q <= 1'b1;
            force_q   <= 1'b1;
            nsr_q     <= 1'b1;
            dma_q     <= 1'b0;
            spi_q     <= 1'b0;
            trig_q    <= 1'b0;
            irq_q     <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            code_q    <= code_d;
            board_q   <= board_d;
            sys_rst_q <= sys_rst_d;
            force_q   <= force_d;
            nsr_q     <= nsr_d;
            dma_q     <= dma_d;
            spi_q     <= spi_d;
            trig_q    <= trig_d;
            irq_q     <= irq_d;
            pend_q    <= pend_d;
        end
    end

`ifdef HW_SUPERVISOR_FAULT_LOG_EN
    // Fault halts snapshot every active unmasked source; other halts (PS
    // shutdown, timeouts) record just their own code bit.
    logic [15:0] bitmap_q;
    logic        halt_is_fault;
    assign halt_is_fault = (halt_code >= 8'(FAULT_CODE_LO)) && (halt_code <= 8'(FAULT_CODE_HI));

    always_ff @(posedge clk) begin
        if (rst) begin
            bitmap_q <= '0;
        end else if (halt) begin
            bitmap_q <= halt_is_fault ? fault_act : (16'd1 << halt_code[3:0]);
        end else if (state_q == ST_HALTED && !bus.sys_en) begin
            bitmap_q <= '0;
        end
    end
    assign bus.fault_bitmap = bitmap_q;
`else
    assign bus.fault_bitmap = '0;
`endif

    always_comb begin
        bus.status_word = '0;
        bus.status_word[SW_STATE_LSB +: 4]       = state_q;
        bus.status_word[SW_CODE_LSB +: 8]        = code_q;
        bus.status_word[SW_BOARD_LSB +: BOARD_W] = board_q;
    end

    assign bus.sys_rst        = sys_rst_q;
    assign bus.shutdown_force = force_q;
    assign bus.n_shutdown_rst = nsr_q;
    assign bus.dma_en         = dma_q;
    assign bus.spi_en         = spi_q;
    assign bus.trig_en        = trig_q;
    assign bus.ps_interrupt   = irq_q;

endmodule

// File: tb/tb_hw_supervisor.sv
// Purpose: directed self-checking bench for hw_supervisor (start-up, faults, stop, timeouts, reset).
// Latency: inputs change and outputs are sampled on the falling edge, half a cycle after the DUT updates.
// Backpressure: n/a.
module tb_hw_supervisor;
    localparam int NB = 8;
    localparam int BW = 8;
    localparam int TW = 32;

`ifdef HW_SUPERVISOR_FAULT_LOG_EN
    localparam bit LOG_EN = 1'b1;
`else
    localparam bit LOG_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    hw_supervisor_if #(.N_BOARDS(NB), .BOARD_W(BW), .TIMER_W(TW)) bus ();

    hw_supervisor #(.N_BOARDS(NB), .BOARD_W(BW), .TIMER_W(TW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // {sys_rst, shutdown_force, n_shutdown_rst, dma_en, spi_en, trig_en}
    function automatic logic [31:0] ctl();
        return {26'd0, bus.sys_rst, bus.shutdown_force, bus.n_shutdown_rst,
                bus.dma_en, bus.spi_en, bus.trig_en};
    endfunction

    function automatic logic [31:0] exp_bm(input logic [15:0] v);
        return LOG_EN ? {16'd0, v} : 32'd0;
    endfunction

    task automatic run_until(input logic [3:0] st, input string tag);
        for (int n = 0; n < 40 && bus.status_word[3:0] != st; n++) tick();
        check(tag, {28'd0, bus.status_word[3:0]}, {28'd0, st});
    endtask

    task automatic clear_faults();
        bus.over_thresh    = '0;
        bus.dac_empty_read = '0;
        bus.adc_full_write = '0;
        bus.premat_trig    = '0;
        bus.premat_dac_div = '0;
        bus.premat_adc_div = '0;
        bus.ext_shutdown   = 1'b0;
        bus.shutdown_sense = 1'b0;
        bus.sense_num      = '0;
    endtask

    // From IDLE to RUNNING, plus one settle cycle so the entry pulse is gone.
    task automatic bring_up(input string tag);
        bus.sys_en       = 1'b1;
        bus.dac_buf_full = 1'b1;
        bus.spi_running  = 1'b1;
        run_until(4'd5, tag);
        tick();
    endtask

    initial begin
        int cnt;
        rst                = 1'b1;
        bus.sys_en         = 1'b0;
        bus.poweron_wait   = 32'd4;
        bus.buf_load_wait  = 32'd4;
        bus.spi_start_wait = 32'd4;
        bus.spi_stop_wait  = 32'd4;
        bus.fault_mask     = 16'h0000;
        bus.dac_buf_full   = 1'b0;
        bus.spi_running    = 1'b0;
        clear_faults();
        tick();
        tick();
        check("rst_status", bus.status_word, 32'h0000_0011);
        check("rst_ctl", ctl(), 32'h38);
        check("rst_irq", {31'd0, bus.ps_interrupt}, 32'd0);
        check("rst_bitmap", {16'd0, bus.fault_bitmap}, 32'd0);
        rst = 1'b0;

        // Nominal start-up
        bus.sys_en = 1'b1;
        tick();
        check("pwr_enter", bus.status_word, 32'h12);
        check("pwr_ctl", ctl(), 32'h00);
        repeat (4) tick();
        check("pwr_last", bus.status_word, 32'h12);
        tick();
        check("dma_enter", bus.status_word, 32'h13);
        check("dma_ctl", ctl(), 32'h0C);
        bus.dac_buf_full = 1'b1;
        tick();
        check("spi_enter", bus.status_word, 32'h14);
        check("spi_ctl", ctl(), 32'h0E);
        check("spi_irq", {31'd0, bus.ps_interrupt}, 32'd0);
        tick();
        check("spi_wait", bus.status_word, 32'h14);
        bus.spi_running = 1'b1;
        tick();
        check("run_status", bus.status_word, 32'h15);
        check("run_ctl", ctl(), 32'h0F);
        check("run_irq", {31'd0, bus.ps_interrupt}, 32'd1);
        tick();
        check("run_irq_off", {31'd0, bus.ps_interrupt}, 32'd0);

        // Two per-board faults at once: DAC_EMPTY_READ outranks PREMAT_TRIG
        bus.premat_trig    = 8'h28;
        bus.dac_empty_read = 8'h80;
        tick();
        check("flt_status", bus.status_word, 32'h0000_7086);
        check("flt_ctl", ctl(), 32'h38);
        check("flt_irq", {31'd0, bus.ps_interrupt}, 32'd1);
        check("flt_bitmap", {16'd0, bus.fault_bitmap}, exp_bm(16'h0500));
        tick();
        check("flt_hold", bus.status_word, 32'h0000_7086);
        check("flt_irq_off", {31'd0, bus.ps_interrupt}, 32'd0);
        clear_faults();
        bus.sys_en = 1'b0;
        tick();
        check("flt_idle", bus.status_word, 32'h11);
        check("flt_bm_clr", {16'd0, bus.fault_bitmap}, 32'd0);

        // Same faults with DAC_EMPTY_READ masked
        bus.fault_mask = 16'h0100;
        bring_up("mask_up");
        bus.premat_trig    = 8'h28;
        bus.dac_empty_read = 8'h80;
        tick();
        check("mask_status", bus.status_word, 32'h0000_30A6);
        check("mask_bitmap", {16'd0, bus.fault_bitmap}, exp_bm(16'h0400));
        clear_faults();
        bus.fault_mask = 16'h0000;
        bus.sys_en = 1'b0;
        tick();

        // Graceful stop: spi_running drops after three STOPPING cycles
        bring_up("stop_up");
        bus.sys_en = 1'b0;
        tick();
        check("stop_enter", bus.status_word, 32'h17);
        check("stop_ctl", ctl(), 32'h0C);
        tick();
        check("stop_c2", bus.status_word, 32'h17);
        tick();
        check("stop_c3", bus.status_word, 32'h17);
        bus.spi_running = 1'b0;
        tick();
        check("stop_halt", bus.status_word, 32'h26);
        check("stop_bitmap", {16'd0, bus.fault_bitmap}, exp_bm(16'h0004));
        tick();
        check("stop_idle", bus.status_word, 32'h11);

        // Stop timeout: spi_running stays high, spi_stop_wait=10
        bus.spi_stop_wait = 32'd10;
        bring_up("sto_up");
        bus.sys_en = 1'b0;
        tick();
        cnt = 0;
        while (bus.status_word[3:0] == 4'd7 && cnt < 30) begin
            cnt++;
            tick();
        end
        check("sto_cycles", cnt, 32'd11);
        check("sto_status", bus.status_word, 32'hD6);
        check("sto_bitmap", {16'd0, bus.fault_bitmap}, exp_bm(16'h2000));
        tick();
        bus.spi_stop_wait = 32'd4;

        // Buffer-fill timeout with buf_load_wait=0
        bus.buf_load_wait = 32'd0;
        bus.dac_buf_full  = 1'b0;
        bus.spi_running   = 1'b0;
        bus.sys_en        = 1'b1;
        run_until(4'd3, "buf_reach");
        tick();
        check("buf_status", bus.status_word, 32'h36);
        check("buf_irq", {31'd0, bus.ps_interrupt}, 32'd1);
        check("buf_bitmap", {16'd0, bus.fault_bitmap}, exp_bm(16'h0008));
        bus.sys_en = 1'b0;
        tick();
        bus.buf_load_wait = 32'd4;

        // Abort in START_SPI on the same cycle spi_running rises
        bus.dac_buf_full = 1'b1;
        bus.sys_en       = 1'b1;
        run_until(4'd4, "abort_reach");
        bus.sys_en      = 1'b0;
        bus.spi_running = 1'b1;
        tick();
        check("abort_status", bus.status_word, 32'h26);
        tick();
        check("abort_idle", bus.status_word, 32'h11);

        // over_thresh outranks ext_shutdown; both logged
        bring_up("ext_up");
        bus.over_thresh  = 8'h01;
        bus.ext_shutdown = 1'b1;
        tick();
        check("ext_status", bus.status_word, 32'h56);
        check("ext_bitmap", {16'd0, bus.fault_bitmap}, exp_bm(16'h00A0));
        clear_faults();
        bus.sys_en = 1'b0;
        tick();

        // shutdown_sense reports sense_num as the board
        bring_up("sense_up");
        bus.shutdown_sense = 1'b1;
        bus.sense_num      = 8'h2C;
        bus.adc_full_write = 8'h01;
        tick();
        check("sense_status", bus.status_word, 32'h0002_C066);
        check("sense_bitmap", {16'd0, bus.fault_bitmap}, exp_bm(16'h0240));
        clear_faults();
        bus.sys_en = 1'b0;
        tick();

        // Reset while RUNNING
        bring_up("rst_up");
        rst = 1'b1;
        tick();
        check("mrst_status", bus.status_word, 32'h0000_0011);
        check("mrst_ctl", ctl(), 32'h38);
        check("mrst_irq", {31'd0, bus.ps_interrupt}, 32'd0);
        check("mrst_bitmap", {16'd0, bus.fault_bitmap}, 32'd0);
        rst = 1'b0;
        bus.sys_en = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hw_supervisor.md
Name: hw_supervisor

Overview:
- Parametrised successor to the rev-D hardware manager FSM.
- Sequences power-on, DMA preload and SPI start for N_BOARDS boards.
- Monitors per-board and global fault sources, halts the system and reports first cause and board.
- New in this generation: runtime timeouts, graceful SPI stop on disable, abort during startup, per-code fault mask, wider board index.

Parameters:
N_BOARDS, 8, number of boards; 1..256
BOARD_W, 8, width of board index field (must satisfy 2^BOARD_W >= N_BOARDS)
TIMER_W, 32, width of timer and timeout inputs

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
sys_en  in  1  system enable from PS
poweron_wait / buf_load_wait / spi_start_wait / spi_stop_wait  in  TIMER_W each  runtime timeouts, in cycles
fault_mask  in  16  bit k=1 ignores status code k (bits 0,1 ignored)
dac_buf_full, spi_running, ext_shutdown, shutdown_sense  in  1  as previous generation
sense_num  in  BOARD_W  board reporting shutdown_sense
over_thresh, dac_empty_read, adc_full_write, premat_trig, premat_dac_div, premat_adc_div  in  N_BOARDS each  per-board faults
sys_rst, dma_en, spi_en, trig_en, shutdown_force, n_shutdown_rst  out  1  control outputs
status_word  out  32  [3:0] state, [11:4] status code, [11+BOARD_W:12] board, rest 0
fault_bitmap  out  16  see Optional Feature
ps_interrupt  out  1  single-cycle pulse

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset values: state IDLE, sys_rst=1, shutdown_force=1, n_shutdown_rst=1, dma_en=0, spi_en=0, trig_en=0, code OK(1), board 0, timer 0, ps_interrupt=0, fault_bitmap 0.
- State encodings: IDLE=1, POWERON=2, START_DMA=3, START_SPI=4, RUNNING=5, HALTED=6, STOPPING=7.
- Status codes: OK=1, PS_SHUTDOWN=2, BUF_FILL_TIMEOUT=3, SPI_START_TIMEOUT=4, OVER_THRESH=5, SHUTDOWN_SENSE=6, EXT_SHUTDOWN=7, DAC_EMPTY_READ=8, ADC_FULL_WRITE=9, PREMAT_TRIG=A, PREMAT_DAC_DIV=B, PREMAT_ADC_DIV=C, SPI_STOP_TIMEOUT=D.
- Timer: cleared on every state entry. Each cycle the exit condition is false and timer < wait, timer increments. Timeout fires when timer == wait with the condition still false, i.e. on cycle wait+1 in the state. wait=0 times out on the first cycle. Timeout inputs are sampled live.
- IDLE: on sys_en -> POWERON; sys_rst=0, shutdown_force=0, n_shutdown_rst=0.
- POWERON: at timeout -> START_DMA; n_shutdown_rst=1, dma_en=1.
- START_DMA: dac_buf_full -> START_SPI with spi_en=1. Timeout -> HALT with code 3.
- START_SPI: spi_running -> RUNNING with trig_en=1 and interrupt pulse. Timeout -> HALT with code 4.
- sys_en low in POWERON, START_DMA or START_SPI -> HALT with code 2. This takes precedence over a same-cycle timeout or advance.
- Fault priority in RUNNING and STOPPING (highest first): over_thresh, shutdown_sense, ext_shutdown, dac_empty_read, adc_full_write, premat_trig, premat_dac_div, premat_adc_div.
  - A source whose code bit is set in fault_mask is ignored.
  - For per-board buses, board = lowest set bit index.
- RUNNING:
  - Any unmasked fault -> HALT with that code.
  - Otherwise, sys_en low -> STOPPING; trig_en=0, spi_en=0, other outputs unchanged.
- STOPPING:
  - Unmasked fault -> HALT with that code.
  - Otherwise, !spi_running -> HALT with code 2.
  - Timeout (spi_stop_wait) -> HALT with code D.
- HALT action: state HALTED; sys_rst=1, shutdown_force=1, dma_en=0, spi_en=0, trig_en=0; latch code and board; interrupt pulse.
- HALTED: code and board held. When sys_en is low -> IDLE with code OK and board 0. sys_en high holds HALTED indefinitely.
- ps_interrupt is high for exactly the cycle after entering RUNNING or HALTED; it is never high two consecutive cycles.

Optional Feature:
- Macro: HW_SUPERVISOR_FAULT_LOG_EN.
- Defined: at each HALT, fault_bitmap latches bit k=1 for every unmasked source with code k active that cycle, including the reported one. For timeout halts only the timeout bit is set. Cleared on HALTED->IDLE and on rst.
- Undefined: fault_bitmap is constant 0 and no logging flops are synthesised.

Decomposition:
- Package hw_supervisor_pkg: state and status-code constants, status_word field offsets.
- Sub-module lsb_encoder (parameter WIDTH; outputs valid and the index of the lowest set bit). One instance per per-board fault bus.

Test Plan:
- Nominal start: all waits=4, sys_en=1, dac_buf_full at cycle 8, spi_running 2 cycles later -> states 2,3,4,5 in order; POWERON lasts 5 cycles; interrupt pulse on entering RUNNING; code 1.
- Fault reporting: in RUNNING, premat_trig=8'h28 and dac_empty_read=8'h80 together -> HALTED; code 8, board 7; all enables 0; sys_rst=1. With fault_mask bit 8 set instead -> code A, board 3.
- Graceful stop: in RUNNING, drop sys_en; spi_running falls 3 cycles later -> STOPPING for 3 cycles, then HALTED with code 2, then IDLE the next cycle. A second run with spi_running held high and spi_stop_wait=10 -> code D after 11 cycles.
- Startup timeouts: dac_buf_full never asserts with buf_load_wait=0 -> HALTED with code 3 on the first START_DMA cycle. In START_SPI, drop sys_en on the same cycle spi_running rises -> code 2, never RUNNING.
- Reset mid-run: assert rst in RUNNING -> next edge gives every output at its reset value and status_word=32'h00000011.
- Feature build: HW_SUPERVISOR_FAULT_LOG_EN defined, over_thresh and ext_shutdown both high -> code 5, fault_bitmap=16'h00A0. Macro undefined -> fault_bitmap=0.
